minv_mdiv_engine: RTL and testbench
===================================

// Module: minv_mdiv_engine
// PURPOSE
//  Parametrised modular-inverse / modular-division engine (binary extended Euclid), next generation
//  of the word-serial MINV/MDIV unit. Operands a, b, p of OPW bits load over a DW-bit bus.
//  Result streams out with a valid/ready handshake. Adds an error flag and back-pressure.
//  Sits behind the e203 NICE/accelerator glue; one operation in flight.
// PARAMETERS
//  OPW  256  operand width in bits; multiple of DW, >= 2*DW
//  DW   32   load/unload bus width
//  NW   OPW/DW (localparam) words per operand
// PORTS
//  clk        in   1    clock
//  rst        in   1    asynchronous reset, active-low
//  datain     in   DW   load data word
//  loada      in   1    shift datain into reg A (ignored unless IDLE)
//  loadb      in   1    shift datain into reg B (dividend, MDIV only; ignored unless IDLE)
//  loadp      in   1    shift datain into reg P (modulus; ignored unless IDLE)
//  minv_mdiv  in   1    1 = inverse (x1 init 1), 0 = division (x1 init B); sampled on start
//  start      in   1    start pulse; ignored unless IDLE
//  busy       out  1    high from the cycle after start until last result word accepted
//  err        out  1    operation failed (see BEHAVIOUR); valid while out_valid is high
//  out_valid  out  1    result word available
//  out_ready  in   1    consumer accepts word when out_valid & out_ready
//  result_out out  DW   result word, LSW first
// BEHAVIOUR
//  - Reset: busy=0, err=0, out_valid=0, result_out=0, FSM=IDLE, step counter=0; A/B/P cleared.
//  - Load: each strobe does reg <= {datain, reg[OPW-1:DW]}; after NW strobes the first word is the LSW.
//    Loads are ignored while busy. Simultaneous loada/loadb/loadp each write datain into their own reg.
//  - FSM: IDLE -start-> CHECK -> RUN -> FIN -> OUT -(NW handshakes)-> IDLE.
//  - CHECK (1 cycle): err=1 and go FIN if P[0]==0, P<3, A==0 or A>=P. Otherwise u=A, v=P, x2=0,
//    x1 = minv_mdiv ? 1 : B. B>=P is reduced with one subtraction, B-P.
//  - RUN, exactly one action per cycle, evaluated in priority order:
//    1) u==1 or v==1 -> FIN
//    2) u==0 -> err=1, FIN (gcd>1)
//    3) u even: u>>=1; x1=halve(x1)
//    4) v even: v>>=1; x2=halve(x2)
//    5) u>=v: u-=v; x1=msub(x1,x2)
//    6) else: v-=u; x2=msub(x2,x1)
//  - halve(x) = (x + (x[0] ? P : 0)) >> 1, computed in OPW+1 bits.
//  - msub(x,y) = x-y, plus P if it borrows; result always in [0,P-1].
//  - FIN (1 cycle): result = (u==1) ? x1 : x2, or 0 if err. Load result into the output shifter.
//  - OUT: out_valid=1 and result_out = current LSW word. Each handshake shifts right by DW.
//    The NW-th handshake drops out_valid and busy in the same cycle, returning to IDLE.
//    With out_ready held low, the word and out_valid hold indefinitely.
//  - Latency: start -> out_valid <= 4*OPW+3 cycles. a==1 gives out_valid at cycle 3 (CHECK, RUN, FIN).
//  - start during busy is ignored and does not restart. Async reset at any point aborts, returns to reset state.
//  - A, B, P are preserved after completion, so a new start reuses the loaded operands.
// CONFIGURATION
//  MINV_MDIV_TIMEOUT_EN defined: a step counter counts RUN cycles.
//    Reaching 4*OPW+4 forces err=1 and FIN (zero result).
//  Undefined: no counter; RUN ends only by rules 1 or 2 (the algorithm guarantees termination).
// STRUCTURE
//  - minv_mdiv_pkg.vh (shared include): FSM state encodings, default OPW/DW, timeout constant, err codes.
//  - Sub-module minv_mod_arith: combinational halve/msub/compare on OPW bits.
//    Instantiated once, because only one x-update happens per cycle.
//  - Top holds regs A/B/P/u/v/x1/x2, the FSM, load shifters and the output shifter.
// TESTING (OPW=64, DW=32 unless noted)
//  - P=23, A=3, minv=1, start -> result words {8,0}, err=0, busy low after 2nd handshake.
//  - P=23, A=3, B=5, minv=0 -> result 17, err=0; repeat with B=28 (>=P) -> 17.
//  - A=1, P=23 -> result 1, out_valid on 3rd cycle after start; A=0 -> err=1, result 0.
//  - P=24 (even) or A=23 -> err=1 after CHECK, result 0.
//  - OPW=256, P=secp256k1 prime, random A x200 vs model; out_ready toggled randomly ->
//    words held stable while stalled, all match.
//  - rst low mid-RUN -> all outputs 0 next edge. Start with no reload -> same result as before.
//    loada/start during busy -> no effect.

Source files
------------

// File: rtl/minv_mdiv_engine_pkg.sv
// Shared definitions for the modular-inverse / modular-division engine.
//   state_e        : engine FSM states
//   DefOpw / DefDw : default operand and bus widths
//   ErrNone/ErrFail: values carried on the err output
//   timeout_steps  : RUN-cycle budget used when MINV_MDIV_TIMEOUT_EN is defined
package minv_mdiv_engine_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StRun   = 3'd2,
    StFin   = 3'd3,
    StOut   = 3'd4
  } state_e;

  localparam int unsigned DefOpw = 256;
  localparam int unsigned DefDw  = 32;

  localparam logic ErrNone = 1'b0;
  localparam logic ErrFail = 1'b1;

  // Binary extended Euclid finishes well inside 4*OPW steps; anything beyond is a fault.
  function automatic int unsigned timeout_steps(int unsigned opw);
    return 4 * opw + 4;
  endfunction

endpackage

// File: rtl/minv_mdiv_engine_if.sv
// Load / start / result-stream bundle of the modular-inverse / division engine.
//   master : operand source and result consumer (drives datain, load strobes, start, out_ready)
//   slave  : the engine (drives busy, err, out_valid, result_out)
interface minv_mdiv_engine_if
  import minv_mdiv_engine_pkg::*;
#(
  parameter int unsigned DW = DefDw
) ();

  logic [DW-1:0] datain;
  logic          loada;
  logic          loadb;
  logic          loadp;
  logic          minv_mdiv;
  logic          start;
  logic          busy;
  logic          err;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result_out;

  modport master (
    output datain, loada, loadb, loadp, minv_mdiv, start, out_ready,
    input  busy, err, out_valid, result_out
  );

  modport slave (
    input  datain, loada, loadb, loadp, minv_mdiv, start, out_ready,
    output busy, err, out_valid, result_out
  );

endinterface

// File: rtl/minv_mdiv_engine_arith.sv
// Combinational modular helpers on OPW-bit values, modulus p_i.
//   hx_i -> halve_o : (x + (x odd ? p : 0)) / 2, i.e. x/2 mod p for x < p
//   mx_i, my_i -> msub_o : (x - y) mod p, for x, y in [0, p-1]
//   ca_i, cb_i -> ge_o   : ca_i >= cb_i
// Only one x-register update happens per cycle, so the top shares one instance.
module minv_mdiv_engine_arith #(
  parameter int unsigned OPW = 256
) (
  input  logic [OPW-1:0] p_i,
  input  logic [OPW-1:0] hx_i,
  input  logic [OPW-1:0] mx_i,
  input  logic [OPW-1:0] my_i,
  input  logic [OPW-1:0] ca_i,
  input  logic [OPW-1:0] cb_i,
  output logic [OPW-1:0] halve_o,
  output logic [OPW-1:0] msub_o,
  output logic           ge_o
);

  logic [OPW:0] sum;
  logic [OPW:0] diff;

  always_comb begin
    // Extra bit keeps the carry of x + p before the shift.
    sum     = {1'b0, hx_i} + (hx_i[0] ? {1'b0, p_i} : '0);
    halve_o = sum[OPW:1];

    // Borrow out means x < y; adding p wraps back into [0, p-1] modulo 2^OPW.
    diff    = {1'b0, mx_i} - {1'b0, my_i};
    msub_o  = diff[OPW] ? (diff[OPW-1:0] + p_i) : diff[OPW-1:0];

    ge_o    = (ca_i >= cb_i);
  end

endmodule

// File: rtl/minv_mdiv_engine.sv
// Modular inverse / modular division engine (binary extended Euclid).
// Computes x1_init / A mod P, with x1_init = 1 (inverse) or B (division).
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : slave side of minv_mdiv_engine_if (DW-bit operand load, start, result stream)
// Operands shift in LSW first; the result streams out LSW first over NW valid/ready beats.
// Optional macro MINV_MDIV_TIMEOUT_EN adds a RUN-cycle counter that aborts with err after
// timeout_steps(OPW) cycles.
module minv_mdiv_engine
  import minv_mdiv_engine_pkg::*;
#(
  parameter int unsigned OPW = DefOpw,
  parameter int unsigned DW  = DefDw
) (
  input logic                clk,
  input logic                rst,
  minv_mdiv_engine_if.slave  bus
);

  localparam int unsigned NW  = OPW / DW;
  localparam int unsigned WCW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [OPW-1:0] One   = OPW'(1);
  localparam logic [OPW-1:0] Three = OPW'(3);

  state_e         state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [OPW-1:0] u_q, u_d, v_q, v_d;
  logic [OPW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [OPW-1:0] out_q, out_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           mode_q, mode_d;
  logic           err_q, err_d;

`ifdef MINV_MDIV_TIMEOUT_EN
  localparam int unsigned TimeoutSteps = timeout_steps(OPW);
  localparam int unsigned SCW          = $clog2(TimeoutSteps + 1);
  logic [SCW-1:0] step_q, step_d;
`endif

  logic [OPW-1:0] halve_x, halve_res;
  logic [OPW-1:0] msub_x, msub_y, msub_res;
  logic           u_ge_v;

  // Operand routing: rule 3 halves x1, rule 4 halves x2; rule 5 is x1-x2, rule 6 x2-x1.
  always_comb begin
    halve_x = u_q[0] ? x2_q : x1_q;
    msub_x  = u_ge_v ? x1_q : x2_q;
    msub_y  = u_ge_v ? x2_q : x1_q;
  end

  minv_mdiv_engine_arith #(
    .OPW (OPW)
  ) u_arith (
    .p_i     (p_q),
    .hx_i    (halve_x),
    .mx_i    (msub_x),
    .my_i    (msub_y),
    .ca_i    (u_q),
    .cb_i    (v_q),
    .halve_o (halve_res),
    .msub_o  (msub_res),
    .ge_o    (u_ge_v)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    out_d   = out_q;
    wcnt_d  = wcnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
`ifdef MINV_MDIV_TIMEOUT_EN
    step_d  = step_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.loada) a_d = {bus.datain, a_q[OPW-1:DW]};
        if (bus.loadb) b_d = {bus.datain, b_q[OPW-1:DW]};
        if (bus.loadp) p_d = {bus.datain, p_q[OPW-1:DW]};
        if (bus.start) begin
          mode_d  = bus.minv_mdiv;
          err_d   = ErrNone;
          state_d = StCheck;
        end
      end

      StCheck: begin
`ifdef MINV_MDIV_TIMEOUT_EN
        step_d = '0;
`endif
        if (!p_q[0] || (p_q < Three) || (a_q == '0) || (a_q >= p_q)) begin
          err_d   = ErrFail;
          state_d = StFin;
        end else begin
          u_d     = a_q;
          v_d     = p_q;
          x2_d    = '0;
          // B in [P, 2P) is brought into range with a single subtraction.
          x1_d    = mode_q ? One : ((b_q >= p_q) ? (b_q - p_q) : b_q);
          state_d = StRun;
        end
      end

      StRun: begin
`ifdef MINV_MDIV_TIMEOUT_EN
        step_d = step_q + SCW'(1);
        if (step_q == SCW'(TimeoutSteps)) begin
          err_d   = ErrFail;
          state_d = StFin;
        end else
`endif
        if ((u_q == One) || (v_q == One)) begin
          state_d = StFin;
        end else if (u_q == '0) begin
          // u collapsed onto v: gcd(A, P) > 1, no inverse exists.
          err_d   = ErrFail;
          state_d = StFin;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = halve_res;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = halve_res;
        end else if (u_ge_v) begin
          u_d  = u_q - v_q;
          x1_d = msub_res;
        end else begin
          v_d  = v_q - u_q;
          x2_d = msub_res;
        end
      end

      StFin: begin
        if (err_q) begin
          out_d = '0;
        end else begin
          out_d = (u_q == One) ? x1_q : x2_q;
        end
        wcnt_d  = '0;
        state_d = StOut;
      end

      StOut: begin
        if (bus.out_ready) begin
          out_d = out_q >> DW;
          if (wcnt_q == WCW'(NW - 1)) begin
            state_d = StIdle;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      out_q   <= '0;
      wcnt_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= ErrNone;
`ifdef MINV_MDIV_TIMEOUT_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      out_q   <= out_d;
      wcnt_q  <= wcnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
`ifdef MINV_MDIV_TIMEOUT_EN
      step_q  <= step_d;
`endif
    end
  end

  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.out_valid  = (state_q == StOut);
    bus.err        = err_q & (state_q == StOut);
    bus.result_out = out_q[DW-1:0];
  end

endmodule

// File: tb/tb_minv_mdiv_engine.sv
// Self-checking bench for minv_mdiv_engine: a 64-bit and a 256-bit instance share one
// stimulus set; sel256 routes strobes and outputs. Expected results come from a
// division-based extended Euclid model over wide integers.
module tb_minv_mdiv_engine;

  localparam logic [255:0] Secp = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] datain = '0;
  logic        loada = 0, loadb = 0, loadp = 0, minv_mdiv = 0, start = 0, out_ready = 0;
  logic        sel256 = 0;
  logic        busy, err, out_valid;
  logic [31:0] result_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minv_mdiv_engine_if #(.DW(32)) if64 ();
  minv_mdiv_engine_if #(.DW(32)) if256 ();

  assign if64.datain     = datain;
  assign if64.loada      = loada & ~sel256;
  assign if64.loadb      = loadb & ~sel256;
  assign if64.loadp      = loadp & ~sel256;
  assign if64.minv_mdiv  = minv_mdiv;
  assign if64.start      = start & ~sel256;
  assign if64.out_ready  = out_ready & ~sel256;
  assign if256.datain    = datain;
  assign if256.loada     = loada & sel256;
  assign if256.loadb     = loadb & sel256;
  assign if256.loadp     = loadp & sel256;
  assign if256.minv_mdiv = minv_mdiv;
  assign if256.start     = start & sel256;
  assign if256.out_ready = out_ready & sel256;

  always_comb begin
    if (sel256) begin
      busy = if256.busy; err = if256.err; out_valid = if256.out_valid; result_out = if256.result_out;
    end else begin
      busy = if64.busy; err = if64.err; out_valid = if64.out_valid; result_out = if64.result_out;
    end
  end

  minv_mdiv_engine #(.OPW(64), .DW(32)) dut64 (.clk(clk), .rst(rst), .bus(if64));
  minv_mdiv_engine #(.OPW(256), .DW(32)) dut256 (.clk(clk), .rst(rst), .bus(if256));

  // Reference: t * a == r (mod p) is kept for every remainder r of Euclid's algorithm.
  function automatic void model(input logic [255:0] a, input logic [255:0] b,
                                input logic [255:0] p, input logic mode,
                                output logic [255:0] res, output logic e);
    logic [511:0] r0, r1, t0, t1, q, tmp, pp;
    res = '0;
    e   = (p[0] == 1'b0) || (p < 256'd3) || (a == '0) || (a >= p);
    if (e) return;
    pp = {256'b0, p};
    r0 = pp; r1 = {256'b0, a}; t0 = '0; t1 = 512'd1;
    for (int it = 0; it < 4000 && r1 != '0; it++) begin
      q   = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = (t0 + pp - (q * t1) % pp) % pp; t0 = t1; t1 = tmp;
    end
    if (r0 != 512'd1) begin
      e = 1'b1;
      return;
    end
    if (mode) tmp = t0;
    else tmp = (t0 * ({256'b0, b} % pp)) % pp;
    res = tmp[255:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input int which, input logic [255:0] val);
    int nw;
    nw = sel256 ? 8 : 2;
    for (int i = 0; i < nw; i++) begin
      datain = val[32*i +: 32];
      loada = (which == 0); loadb = (which == 1); loadp = (which == 2);
      tick();
    end
    loada = 0; loadb = 0; loadp = 0;
  endtask

  task automatic load_all(input logic [255:0] a, input logic [255:0] b, input logic [255:0] p);
    load_reg(0, a);
    load_reg(1, b);
    load_reg(2, p);
  endtask

  // Starts one operation and drains the result; inject drives loada/loadp/start while busy.
  task automatic run_op(input logic mode, input int unsigned stall_pct, input bit inject,
                        output logic [255:0] res, output logic e, output int lat);
    int nw, opw, k, guard;
    logic [31:0] held;
    bit stalled;
    nw = sel256 ? 8 : 2;
    opw = 32 * nw;
    res = '0; e = 0; lat = 0;
    minv_mdiv = mode; start = 1;
    tick();
    start = 0; minv_mdiv = ~mode;
    while (!out_valid && lat < 4 * opw + 12) begin
      if (inject && (lat == 1 || lat == 2)) begin
        loada = 1; loadp = 1; datain = 32'd5; start = 1;
      end else begin
        loada = 0; loadp = 0; start = 0;
      end
      tick();
      lat++;
    end
    loada = 0; loadp = 0; start = 0;
    checks++;
    if (!out_valid || lat > 4 * opw + 3) begin
      errors++;
      $display("FAIL latency: out_valid=%0b after %0d cycles, required within %0d", out_valid,
               lat, 4 * opw + 3);
      return;
    end
    e = err;
    k = 0; stalled = 0; guard = 0;
    while (k < nw && guard < 1000) begin
      guard++;
      if (out_valid) begin
        if (stalled) begin
          checks++;
          if (result_out !== held) begin
            errors++;
            $display("FAIL stall_hold: word %0d is %h, required held %h", k, result_out, held);
          end
        end
        if (($urandom % 100) >= stall_pct) begin
          out_ready = 1; res[32*k +: 32] = result_out; k++; stalled = 0;
        end else begin
          out_ready = 0; held = result_out; stalled = 1;
        end
      end else begin
        out_ready = 0;
      end
      tick();
    end
    out_ready = 0;
    checks++;
    if (k != nw) begin
      errors++;
      $display("FAIL handshakes: accepted %0d words, required %0d", k, nw);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_idle: busy=%0b out_valid=%0b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    sel256 = 0;
    rst = 0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", err); end
    checks++;
    if (result_out !== 32'd0) begin
      errors++; $display("FAIL reset_result: got %h required 0", result_out);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_minv_basic();
    logic [255:0] res; logic e; int lat;
    sel256 = 0;
    load_all(256'd3, 256'd0, 256'd23);
    run_op(1'b1, 30, 1'b0, res, e, lat);
    checks++;
    if (res[31:0] !== 32'd8) begin errors++; $display("FAIL minv_w0: got %0d required 8", res[31:0]); end
    checks++;
    if (res[63:32] !== 32'd0) begin errors++; $display("FAIL minv_w1: got %0d required 0", res[63:32]); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL minv_err: got %0b required 0", e); end
  endtask

  task automatic test_mdiv();
    logic [255:0] res; logic e; int lat;
    logic [255:0] bs [2];
    bs[0] = 256'd5; bs[1] = 256'd28;
    sel256 = 0;
    foreach (bs[i]) begin
      load_all(256'd3, bs[i], 256'd23);
      run_op(1'b0, 30, 1'b0, res, e, lat);
      checks++;
      if (res[63:0] !== 64'd17 || e !== 1'b0) begin
        errors++;
        $display("FAIL mdiv_b%0d: got %0d err %0b required 17 err 0", bs[i], res[63:0], e);
      end
    end
  endtask

  task automatic test_one();
    logic [255:0] res; logic e; int lat;
    sel256 = 0;
    load_all(256'd1, 256'd0, 256'd23);
    run_op(1'b1, 0, 1'b0, res, e, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL one_latency: got %0d required 3", lat); end
    checks++;
    if (res[63:0] !== 64'd1 || e !== 1'b0) begin
      errors++; $display("FAIL one_result: got %0d err %0b required 1 err 0", res[63:0], e);
    end
  endtask

  task automatic test_errors();
    logic [255:0] res; logic e; int lat;
    logic [255:0] as [4];
    logic [255:0] ps [4];
    as[0] = 256'd0;  ps[0] = 256'd23;
    as[1] = 256'd3;  ps[1] = 256'd24;
    as[2] = 256'd23; ps[2] = 256'd23;
    as[3] = 256'd1;  ps[3] = 256'd1;
    sel256 = 0;
    foreach (as[i]) begin
      load_all(as[i], 256'd7, ps[i]);
      run_op(1'b1, 20, 1'b0, res, e, lat);
      checks++;
      if (e !== 1'b1 || res[63:0] !== 64'd0) begin
        errors++;
        $display("FAIL err_case%0d: got err %0b res %0d required err 1 res 0", i, e, res[63:0]);
      end
    end
  endtask

  task automatic test_random64(input int n);
    logic [255:0] a, b, p, res, exp_res; logic e, exp_e, mode; int lat;
    sel256 = 0;
    for (int i = 0; i < n; i++) begin
      p = '0; a = '0; b = '0;
      if (i % 3 == 0) p[63:0] = 64'(($urandom % 5000) * 2 + 3);
      else p[63:0] = {$urandom, $urandom} | 64'd1;
      if (p[63:0] < 64'd3) p = 256'd3;
      a[63:0] = {$urandom, $urandom} % p[63:0];
      b[63:0] = {$urandom, $urandom} % p[63:0];
      if (($urandom % 4) == 0 && p[63] == 1'b0) b[63:0] = b[63:0] + p[63:0];
      mode = 1'($urandom % 2);
      model(a, b, p, mode, exp_res, exp_e);
      load_all(a, b, p);
      run_op(mode, 40, 1'b0, res, e, lat);
      checks++;
      if (e !== exp_e || res[63:0] !== exp_res[63:0]) begin
        errors++;
        $display("FAIL rand64_%0d: got res %h err %0b required res %h err %0b", i, res[63:0], e,
                 exp_res[63:0], exp_e);
      end
    end
  endtask

  task automatic test_random256(input int n);
    logic [255:0] a, b, res, exp_res; logic e, exp_e, mode; int lat;
    sel256 = 1;
    load_reg(2, Secp);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) begin
        a[32*w +: 32] = $urandom;
        b[32*w +: 32] = $urandom;
      end
      a = a % Secp;
      b = b % Secp;
      mode = 1'($urandom % 2);
      model(a, b, Secp, mode, exp_res, exp_e);
      load_reg(0, a);
      load_reg(1, b);
      run_op(mode, 40, 1'b0, res, e, lat);
      checks++;
      if (e !== exp_e || res !== exp_res) begin
        errors++;
        $display("FAIL rand256_%0d: got res %h err %0b required res %h err %0b", i, res, e,
                 exp_res, exp_e);
      end
    end
    sel256 = 0;
  endtask

  task automatic test_abort_and_reuse();
    logic [255:0] a, p, res, res2, exp_res; logic e, e2, exp_e; int lat;
    sel256 = 0;
    p = '0; a = '0;
    p[63:0] = 64'hF123_4567_89AB_CDEF;
    a[63:0] = 64'h7654_3210_FEDC_BA99;
    load_all(a, 256'd0, p);
    minv_mdiv = 1; start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %0b required 1", busy); end
    #3 rst = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || result_out !== 32'd0) begin
      errors++;
      $display("FAIL abort_outputs: busy %0b valid %0b err %0b res %h required all 0", busy,
               out_valid, err, result_out);
    end
    @(negedge clk);
    rst = 1;
    tick();
    // Operands were cleared by reset: P == 0 must be rejected.
    run_op(1'b1, 0, 1'b0, res, e, lat);
    checks++;
    if (e !== 1'b1 || res[63:0] !== 64'd0) begin
      errors++; $display("FAIL cleared_ops: got err %0b res %h required err 1 res 0", e, res[63:0]);
    end
    model(a, 256'd0, p, 1'b1, exp_res, exp_e);
    load_all(a, 256'd0, p);
    run_op(1'b1, 30, 1'b0, res, e, lat);
    run_op(1'b1, 30, 1'b0, res2, e2, lat);
    checks++;
    if (res[63:0] !== exp_res[63:0] || e !== exp_e) begin
      errors++; $display("FAIL abort_rerun: got %h err %0b required %h err %0b", res[63:0], e,
                         exp_res[63:0], exp_e);
    end
    checks++;
    if (res2[63:0] !== exp_res[63:0] || e2 !== exp_e) begin
      errors++; $display("FAIL reuse_ops: got %h err %0b required %h err %0b", res2[63:0], e2,
                         exp_res[63:0], exp_e);
    end
  endtask

  task automatic test_busy_ignored();
    logic [255:0] res; logic e; int lat_clean, lat_inj;
    sel256 = 0;
    load_all(256'd3, 256'd0, 256'd23);
    run_op(1'b1, 0, 1'b0, res, e, lat_clean);
    run_op(1'b1, 0, 1'b1, res, e, lat_inj);
    checks++;
    if (res[63:0] !== 64'd8 || e !== 1'b0) begin
      errors++; $display("FAIL busy_inject: got %0d err %0b required 8 err 0", res[63:0], e);
    end
    checks++;
    if (lat_inj !== lat_clean) begin
      errors++; $display("FAIL busy_restart: latency %0d required %0d", lat_inj, lat_clean);
    end
    run_op(1'b1, 0, 1'b0, res, e, lat_clean);
    checks++;
    if (res[63:0] !== 64'd8) begin
      errors++; $display("FAIL busy_load: rerun got %0d required 8", res[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_minv_basic();
    test_mdiv();
    test_one();
    test_errors();
    test_busy_ignored();
    test_random64(40);
    test_abort_and_reuse();
    test_random256(25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
